// File: rtl/text_cell_sequencer8x8_pkg.sv
// Shared definitions for the text cell sequencer: geometry, opcodes, cell layout, FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package text_area_pkg;

  localparam int COLS   = 84;
  localparam int ROWS   = 64;
  localparam int ADDR_W = 13;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  localparam logic [3:0] OP_CURSOR   = 4'b0111;
  localparam logic [3:0] OP_WRITE    = 4'b1000;
  localparam logic [3:0] OP_SET_FG   = 4'b1001;
  localparam logic [3:0] OP_SET_BG   = 4'b1010;
  localparam logic [3:0] OP_SET_CHAR = 4'b1011;
  localparam logic [3:0] OP_FILL     = 4'b1100;
  localparam logic [3:0] OP_CLEAR    = 4'b1101;
  localparam logic [3:0] OP_CONFIG   = 4'b1110;

  // RAM cell word: {FG[15:12], BG[11:8], CHAR[7:0]}
  typedef struct packed {
    logic [3:0] fg;
    logic [3:0] bg;
    logic [7:0] ch;
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MERGE,
    WRITE,
    FILL,
    CLEAR
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] col,
                                                  input logic [ROW_W-1:0] row);
    return {col, row};
  endfunction

  // Replace one field of a cell according to the RMW opcode.
  function automatic cell_t merge_field(input cell_t old, input logic [3:0] op,
                                        input logic [7:0] val);
    cell_t c;
    c = old;
    case (op)
      OP_SET_FG:   c.fg = val[3:0];
      OP_SET_BG:   c.bg = val[3:0];
      OP_SET_CHAR: c.ch = val;
      default:     c = old;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/text_cell_sequencer8x8_if.sv
// Command handshake plus text RAM port A bundle between command source, sequencer and RAM.
// Latency: n/a (signal bundle). slave = sequencer side, master = command source / RAM side.
// Backpressure: i_cmd_valid is held with i_cmd_data until o_cmd_ready.
interface text_cell_sequencer8x8_if;
  import text_area_pkg::*;

  logic              i_cmd_valid;
  logic [31:0]       i_cmd_data;
  logic              o_cmd_ready;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [15:0]       o_ram_wdata;
  logic              o_ram_we;
  logic [15:0]       i_ram_rdata;

  modport slave (
    input  i_cmd_valid, i_cmd_data, i_ram_rdata,
    output o_cmd_ready, o_ram_addr, o_ram_wdata, o_ram_we
  );

  modport master (
    output i_cmd_valid, i_cmd_data, i_ram_rdata,
    input  o_cmd_ready, o_ram_addr, o_ram_wdata, o_ram_we
  );

endinterface

// File: rtl/text_cell_sequencer8x8_cursor.sv
// Text cursor register: load (column clamped), advance with row/screen wrap, or zero.
// Latency: updates on the clock edge where a control input is high; priority zero > set > adv.
// Backpressure: none.
// Ports: i_cmd_clk, i_rst (async, active-high), zero, set/set_row/set_col, adv -> row, col.
module text_cursor8x8
  import text_area_pkg::*;
(
  input  logic             i_cmd_clk,
  input  logic             i_rst,
  input  logic             zero,
  input  logic             set,
  input  logic [ROW_W-1:0] set_row,
  input  logic [COL_W-1:0] set_col,
  input  logic             adv,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  always_ff @(posedge i_cmd_clk or posedge i_rst) begin
    if (i_rst) begin
      row <= '0;
      col <= '0;
    end else if (zero) begin
      row <= '0;
      col <= '0;
    end else if (set) begin
      row <= set_row;
      col <= (set_col > COL_LAST) ? COL_LAST : set_col;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_cell_sequencer8x8.sv
// Command-driven port A controller for the 84x64 text cell RAM: writes, field RMW, fills, clears.
// Latency: write 1 busy cycle, RMW 3, fill N, clear 5376; cursor/config commands 0.
// Backpressure: o_cmd_ready only in IDLE; the source holds its command while ready is low.
// Ports: i_cmd_clk, i_rst (async, active-high), bus (command + RAM port A), o_cursor_row/col, o_busy.
module text_cell_sequencer8x8
  import text_area_pkg::*;
(
  input  logic                    i_cmd_clk,
  input  logic                    i_rst,
  text_cell_sequencer8x8_if.slave bus,
  output logic [ROW_W-1:0]        o_cursor_row,
  output logic [COL_W-1:0]        o_cursor_col,
  output logic                    o_busy
);

  state_t           state, state_nxt;
  logic [3:0]       opcode;
  logic             accept;
  logic [11:0]      fill_cnt;
  logic [ROW_W-1:0] clr_row;
  logic [COL_W-1:0] clr_col;
  logic             clr_last;
  logic [3:0]       rmw_op;
  logic [7:0]       rmw_val;
  logic [15:0]      wdata_q;
  logic             we_q, we_nxt;
  logic             auto_adv;
  logic             cur_set, cur_adv, cur_zero;

  assign opcode   = bus.i_cmd_data[31:28];
  assign accept   = (state == IDLE) && bus.i_cmd_valid;
  assign clr_last = (clr_row == ROW_LAST) && (clr_col == COL_LAST);

  text_cursor8x8 u_cursor (
    .i_cmd_clk (i_cmd_clk),
    .i_rst     (i_rst),
    .zero      (cur_zero),
    .set       (cur_set),
    .set_row   (bus.i_cmd_data[21:16]),
    .set_col   (bus.i_cmd_data[6:0]),
    .adv       (cur_adv),
    .row       (o_cursor_row),
    .col       (o_cursor_col)
  );

  always_ff @(posedge i_cmd_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      we_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      we_q  <= we_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_set   = 1'b0;
    cur_adv   = 1'b0;
    cur_zero  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (opcode)
            OP_CURSOR:                        cur_set   = 1'b1;
            OP_WRITE:                         state_nxt = WRITE;
            OP_SET_FG, OP_SET_BG, OP_SET_CHAR: state_nxt = READ;
            OP_FILL:  if (bus.i_cmd_data[27:16] != 12'd0) state_nxt = FILL;
            OP_CLEAR:                         state_nxt = CLEAR;
            default:                          state_nxt = IDLE;
          endcase
        end
      end
      READ:  state_nxt = MERGE;
      MERGE: state_nxt = WRITE;
      WRITE: begin
        cur_adv   = auto_adv;
        state_nxt = IDLE;
      end
      FILL: begin
        // Fills always advance, independent of the auto-advance setting.
        cur_adv = 1'b1;
        if (fill_cnt == 12'd1) state_nxt = IDLE;
      end
      CLEAR: begin
        if (clr_last) begin
          cur_zero  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    we_nxt = (state_nxt == WRITE) || (state_nxt == FILL) || (state_nxt == CLEAR);
  end

  always_ff @(posedge i_cmd_clk or posedge i_rst) begin
    if (i_rst) begin
      wdata_q  <= '0;
      auto_adv <= 1'b1;
      fill_cnt <= '0;
      clr_row  <= '0;
      clr_col  <= '0;
      rmw_op   <= '0;
      rmw_val  <= '0;
    end else begin
      if (accept) begin
        case (opcode)
          OP_WRITE, OP_CLEAR: wdata_q <= bus.i_cmd_data[15:0];
          OP_FILL: begin
            wdata_q  <= bus.i_cmd_data[15:0];
            fill_cnt <= bus.i_cmd_data[27:16];
          end
          OP_SET_FG, OP_SET_BG, OP_SET_CHAR: begin
            rmw_op  <= opcode;
            rmw_val <= bus.i_cmd_data[7:0];
          end
          OP_CONFIG: auto_adv <= bus.i_cmd_data[0];
          default: ;
        endcase
      end

      // Read data for the address presented in READ is valid during MERGE.
      if (state == MERGE) begin
        wdata_q <= merge_field(cell_t'(bus.i_ram_rdata), rmw_op, rmw_val);
      end

      if (state == FILL) begin
        fill_cnt <= fill_cnt - 12'd1;
      end

      // Row-inner scan; counters wrap back to (0,0) on the last cell, ready for the next clear.
      if (state == CLEAR) begin
        if (clr_row == ROW_LAST) begin
          clr_row <= '0;
          clr_col <= (clr_col == COL_LAST) ? '0 : clr_col + COL_W'(1);
        end else begin
          clr_row <= clr_row + ROW_W'(1);
        end
      end
    end
  end

  assign bus.o_cmd_ready = (state == IDLE);
  assign bus.o_ram_we    = we_q;
  assign bus.o_ram_wdata = wdata_q;
  assign bus.o_ram_addr  = (state == CLEAR) ? cell_addr(clr_col, clr_row)
                                            : cell_addr(o_cursor_col, o_cursor_row);
  assign o_busy          = (state != IDLE);

endmodule

// File: tb/tb_text_cell_sequencer8x8.sv
// Directed bench for the text cell sequencer with a behavioural port A RAM and a write log.
module tb_text_cell_sequencer8x8;

  logic clk;
  logic rst;
  logic [5:0] cur_row;
  logic [6:0] cur_col;
  logic busy;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [0:8191];
  logic [12:0] log_addr [$];
  logic [15:0] log_data [$];

  text_cell_sequencer8x8_if bus ();

  text_cell_sequencer8x8 dut (
    .i_cmd_clk    (clk),
    .i_rst        (rst),
    .bus          (bus),
    .o_cursor_row (cur_row),
    .o_cursor_col (cur_col),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data for the address of one cycle is visible the next.
  always @(posedge clk) begin
    if (bus.o_ram_we) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
    bus.i_ram_rdata <= mem[bus.o_ram_addr];
  end

  always @(negedge clk) begin
    if (bus.o_ram_we) begin
      log_addr.push_back(bus.o_ram_addr);
      log_data.push_back(bus.o_ram_wdata);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: ready=%b after %0d cycles, required 1", bus.o_cmd_ready, n);
    end
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_data  = d;
    @(posedge clk);
    #1;
    bus.i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.o_cmd_ready, bus.o_ram_we, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_ctrl: ready/we/busy=%b required 100",
               {bus.o_cmd_ready, bus.o_ram_we, busy});
    end
    vectors++;
    if (bus.o_ram_addr !== 13'd0 || bus.o_ram_wdata !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", bus.o_ram_addr, bus.o_ram_wdata);
    end
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_cursor: row=%0d col=%0d required 0/0", cur_row, cur_col);
    end
    rst = 1'b0;
  endtask

  task automatic test_corner_write();
    send(32'h703F_0053);
    clear_log();
    send(32'h8000_1F41);
    wait_idle(10);
    vectors++;
    if (log_addr.size() != 1 || log_addr[0] !== 13'h14FF || log_data[0] !== 16'h1F41) begin
      miscompares++;
      $display("FAIL corner_write: writes=%0d addr=%h data=%h required 1/14ff/1f41",
               log_addr.size(), log_addr[0], log_data[0]);
    end
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL corner_wrap: row=%0d col=%0d required 0/0", cur_row, cur_col);
    end
  endtask

  task automatic test_rmw();
    int lo;
    send(32'h7007_0005);
    send(32'h8000_A2C3);
    send(32'h7007_0005);
    clear_log();
    send(32'h9000_0005);
    lo = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_cmd_ready) break;
      lo++;
    end
    vectors++;
    if (lo != 3) begin
      miscompares++;
      $display("FAIL rmw_busy: ready low %0d cycles, required 3", lo);
    end
    vectors++;
    if (log_addr.size() != 1 || log_addr[0] !== 13'h147 || log_data[0] !== 16'h52C3) begin
      miscompares++;
      $display("FAIL rmw_fg: writes=%0d addr=%h data=%h required 1/147/52c3",
               log_addr.size(), log_addr[0], log_data[0]);
    end
    vectors++;
    if (cur_row !== 6'd7 || cur_col !== 7'd6) begin
      miscompares++;
      $display("FAIL rmw_cursor: row=%0d col=%0d required 7/6", cur_row, cur_col);
    end
    // CHAR then BG on a neighbouring cell holding 0x1234.
    send(32'h8000_1234);
    send(32'h7007_0006);
    clear_log();
    send(32'hB000_00AB);
    wait_idle(10);
    send(32'h7007_0006);
    send(32'hA000_000E);
    wait_idle(10);
    vectors++;
    if (log_addr.size() != 2 || log_data[0] !== 16'h12AB || log_data[1] !== 16'h1EAB
        || log_addr[1] !== 13'h187) begin
      miscompares++;
      $display("FAIL rmw_char_bg: writes=%0d data=%h,%h addr=%h required 2/12ab,1eab/187",
               log_addr.size(), log_data[0], log_data[1], log_addr[1]);
    end
  endtask

  task automatic test_fill();
    logic [12:0] exp_a [3];
    exp_a[0] = 13'd5258;
    exp_a[1] = 13'd5322;
    exp_a[2] = 13'd11;
    send(32'h700A_0052);
    clear_log();
    send(32'hC003_0F20);
    wait_idle(20);
    vectors++;
    if (log_addr.size() != 3) begin
      miscompares++;
      $display("FAIL fill_count: writes=%0d required 3", log_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (log_addr[i] !== exp_a[i] || log_data[i] !== 16'h0F20) begin
          miscompares++;
          $display("FAIL fill_cell%0d: addr=%0d data=%h required %0d/0f20",
                   i, log_addr[i], log_data[i], exp_a[i]);
        end
      end
    end
    vectors++;
    if (cur_row !== 6'd11 || cur_col !== 7'd1) begin
      miscompares++;
      $display("FAIL fill_cursor: row=%0d col=%0d required 11/1", cur_row, cur_col);
    end
  endtask

  task automatic test_clear();
    int bad_seq, bad_col, bad_dat, dups;
    logic seen [0:8191];
    bad_seq = 0; bad_col = 0; bad_dat = 0; dups = 0;
    for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
    clear_log();
    send(32'hD000_0720);
    wait_idle(6000);
    vectors++;
    if (log_addr.size() != 5376) begin
      miscompares++;
      $display("FAIL clear_count: writes=%0d required 5376", log_addr.size());
    end
    // Row-inner scan makes the k-th address equal to k.
    for (int i = 0; i < log_addr.size(); i++) begin
      if (log_addr[i] !== 13'(i)) bad_seq++;
      if (log_addr[i][12:6] > 7'd83) bad_col++;
      if (log_data[i] !== 16'h0720) bad_dat++;
      if (seen[log_addr[i]]) dups++;
      seen[log_addr[i]] = 1'b1;
    end
    vectors++;
    if (bad_seq != 0 || bad_col != 0 || bad_dat != 0 || dups != 0) begin
      miscompares++;
      $display("FAIL clear_scan: order=%0d col>83=%0d data=%0d repeats=%0d required 0/0/0/0",
               bad_seq, bad_col, bad_dat, dups);
    end
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0 || bus.o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_end: row=%0d col=%0d ready=%b required 0/0/1",
               cur_row, cur_col, bus.o_cmd_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    send(32'h7005_0009);
    send(32'hD000_0B2B);
    repeat (100) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.o_ram_we !== 1'b0 || bus.o_cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_ctrl: we=%b ready=%b busy=%b required 0/1/0",
               bus.o_ram_we, bus.o_cmd_ready, busy);
    end
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL midreset_cursor: row=%0d col=%0d required 0/0", cur_row, cur_col);
    end
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (mem[5] !== 16'h0B2B || mem[128] !== 16'h0720) begin
      miscompares++;
      $display("FAIL midreset_cells: mem5=%h mem128=%h required 0b2b/0720", mem[5], mem[128]);
    end
    clear_log();
    send(32'h8000_1111);
    wait_idle(10);
    vectors++;
    if (log_addr.size() != 1 || log_addr[0] !== 13'd0 || log_data[0] !== 16'h1111
        || cur_col !== 7'd1) begin
      miscompares++;
      $display("FAIL midreset_write: writes=%0d addr=%h data=%h col=%0d required 1/0/1111/1",
               log_addr.size(), log_addr[0], log_data[0], cur_col);
    end
  endtask

  task automatic test_cursor_config();
    send(32'h7003_0064);
    vectors++;
    if (cur_row !== 6'd3 || cur_col !== 7'd83 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clamp: row=%0d col=%0d busy=%b required 3/83/0", cur_row, cur_col, busy);
    end
    send(32'hE000_0000);
    clear_log();
    send(32'h8000_4444);
    wait_idle(10);
    vectors++;
    if (log_addr.size() != 1 || log_addr[0] !== 13'd5315 || cur_row !== 6'd3
        || cur_col !== 7'd83) begin
      miscompares++;
      $display("FAIL no_advance: writes=%0d addr=%0d row=%0d col=%0d required 1/5315/3/83",
               log_addr.size(), log_addr[0], cur_row, cur_col);
    end
    clear_log();
    send(32'h0000_1234);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL unknown_busy: busy=%b required 0", busy);
    end
    send(32'hC000_5555);
    repeat (4) @(negedge clk);
    vectors++;
    if (log_addr.size() != 0 || cur_row !== 6'd3 || cur_col !== 7'd83) begin
      miscompares++;
      $display("FAIL noop_cmds: writes=%0d row=%0d col=%0d required 0/3/83",
               log_addr.size(), cur_row, cur_col);
    end
  endtask

  task automatic test_back_to_back();
    send(32'hE000_0001);
    send(32'h7000_0000);
    clear_log();
    send(32'h8000_0001);
    send(32'h8000_0002);
    wait_idle(10);
    vectors++;
    if (log_addr.size() != 2 || log_addr[0] !== 13'd0 || log_addr[1] !== 13'd64
        || log_data[0] !== 16'h0001 || log_data[1] !== 16'h0002) begin
      miscompares++;
      $display("FAIL back_to_back: writes=%0d addr=%0d,%0d data=%h,%h required 2/0,64/0001,0002",
               log_addr.size(), log_addr[0], log_addr[1], log_data[0], log_data[1]);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_data  = 32'd0;
    test_reset();
    test_corner_write();
    test_rmw();
    test_fill();
    test_clear();
    test_reset_mid_clear();
    test_cursor_config();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
